instr_sequencer: RTL and testbench

- Upstream feeder for the 10-bit processor. Replaces the hand-set data switches as the source of instruction and immediate words on the D input.
- Holds a small program memory loaded from the switches, then presents words one at a time to the datapath.
- Advances only when the controller consumes a word: IR load (IRin) or immediate/external enable (Ext).
- Sits between the switch/debouncer front end and the top-level D input; clocked by the same debounced step clock as the datapath.

---
 rtl/seq_pkg.sv | 8 +
 rtl/instr_sequencer_prog_mem.sv | 21 ++
 rtl/instr_sequencer.sv | 105 ++++++++++
 tb/tb_instr_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default sizes for the instruction sequencer
package seq_pkg;
   typedef enum logic [1:0] {LOAD, RUN, HALT} seq_state_t;
   localparam int WIDTH_DEF = 10;
   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF = 4;
   localparam logic [WIDTH_DEF-1:0] HALT_WORD_DEF = 10'h000;
endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// prog_mem: DEPTH x WIDTH program store, synchronous write, asynchronous read
//   clk          write clock
//   we/waddr/wdata  write port, sampled on rising clk
//   raddr/rdata  combinational read port
module prog_mem #(
   parameter int WIDTH = seq_pkg::WIDTH_DEF,
   parameter int DEPTH = seq_pkg::DEPTH_DEF,
   parameter int AW = seq_pkg::AW_DEF
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: loads a program from the switches, then feeds it word by word to the datapath D input
//   CLKb      step clock, RST async active-high reset
//   MODE      0 = load, 1 = run; SW/WR switch word and write strobe
//   IR_TAKE / EXT_TAKE  controller consumed the current word
//   D_OUT     word to datapath; PC read pointer; LEN words loaded; FULL LEN==DEPTH
//   HALTED    program exhausted; TAKE_ERR sticky double-take flag
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW = AW_DEF,
   parameter logic [WIDTH-1:0] HALT_WORD = HALT_WORD_DEF
) (
   input  logic             CLKb,
   input  logic             RST,
   input  logic             MODE,
   input  logic [WIDTH-1:0] SW,
   input  logic             WR,
   input  logic             IR_TAKE,
   input  logic             EXT_TAKE,
   output logic [WIDTH-1:0] D_OUT,
   output logic [AW-1:0]    PC,
   output logic [AW:0]      LEN,
   output logic             FULL,
   output logic             HALTED,
   output logic             TAKE_ERR
);
   seq_state_t state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0] len_q, len_d;
   logic err_q, err_d;
   logic we;
   logic [WIDTH-1:0] rdata;
   logic take, last;

   prog_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(CLKb),
      .we(we),
      .waddr(len_q[AW-1:0]),
      .wdata(SW),
      .raddr(pc_q),
      .rdata(rdata)
   );

   assign take = IR_TAKE | EXT_TAKE;
   // the word under PC is the final loaded one
   assign last = ({1'b0, pc_q} + (AW+1)'(1)) == len_q;
   assign FULL = len_q == (AW+1)'(DEPTH);

   always_ff @(posedge CLKb or posedge RST)
      if (RST) begin
         state_q <= LOAD;
         pc_q <= '0;
         len_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         len_q <= len_d;
         err_q <= err_d;
      end

   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      len_d = len_q;
      err_d = err_q;
      we = 1'b0;
      case (state_q)
         LOAD:
            if (MODE) begin
               pc_d = '0;
               state_d = (len_q != '0) ? RUN : HALT;
            end else if (WR && !FULL) begin
               we = 1'b1;
               len_d = len_q + (AW+1)'(1);
            end
         RUN:
            if (!MODE) begin
               state_d = LOAD;
               pc_d = '0;
               len_d = '0;
               err_d = 1'b0;
            end else if (take) begin
               err_d = err_q | (IR_TAKE & EXT_TAKE);
               if (last) state_d = HALT;
               else pc_d = pc_q + AW'(1);
            end
         default:
            if (!MODE) begin
               state_d = LOAD;
               pc_d = '0;
               len_d = '0;
               err_d = 1'b0;
            end
      endcase
   end

   assign D_OUT = (state_q == LOAD) ? SW : (state_q == RUN) ? rdata : HALT_WORD;
   assign PC = pc_q;
   assign LEN = len_q;
   assign HALTED = state_q == HALT;
   assign TAKE_ERR = err_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and randomized checks of instr_sequencer against a program-list model
module tb_instr_sequencer;
   logic CLKb = 0, RST = 0, MODE = 0, WR = 0, IR_TAKE = 0, EXT_TAKE = 0;
   logic [9:0] SW = '0;
   logic [9:0] D_OUT;
   logic [3:0] PC;
   logic [4:0] LEN;
   logic FULL, HALTED, TAKE_ERR;
   int tests = 0, fails = 0;

   instr_sequencer dut (
      .CLKb(CLKb), .RST(RST), .MODE(MODE), .SW(SW), .WR(WR),
      .IR_TAKE(IR_TAKE), .EXT_TAKE(EXT_TAKE), .D_OUT(D_OUT), .PC(PC),
      .LEN(LEN), .FULL(FULL), .HALTED(HALTED), .TAKE_ERR(TAKE_ERR)
   );

   always #5 CLKb = ~CLKb;

   // model: prog holds the loaded words, running/halted describe the phase
   logic [9:0] prog [$];
   int m_pc = 0;
   bit running = 0, halted = 0, m_err = 0;

   function automatic void m_reset();
      prog.delete();
      m_pc = 0;
      running = 0;
      halted = 0;
      m_err = 0;
   endfunction

   function automatic void m_edge();
      if (!running && !halted) begin
         if (MODE) begin
            m_pc = 0;
            if (prog.size() > 0) running = 1; else halted = 1;
         end else if (WR && prog.size() < 16) prog.push_back(SW);
      end else if (!MODE) m_reset();
      else if (running && (IR_TAKE || EXT_TAKE)) begin
         if (IR_TAKE && EXT_TAKE) m_err = 1;
         if (m_pc == prog.size() - 1) begin
            running = 0;
            halted = 1;
         end else m_pc++;
      end
   endfunction

   task automatic chk(string tag, int obs, int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(string tag);
      int exp_d;
      exp_d = running ? int'(prog[m_pc]) : halted ? 0 : int'(SW);
      chk({tag, ".D_OUT"}, int'(D_OUT), exp_d);
      chk({tag, ".PC"}, int'(PC), m_pc);
      chk({tag, ".LEN"}, int'(LEN), prog.size());
      chk({tag, ".FULL"}, int'(FULL), int'(prog.size() == 16));
      chk({tag, ".HALTED"}, int'(HALTED), int'(halted));
      chk({tag, ".TAKE_ERR"}, int'(TAKE_ERR), int'(m_err));
   endtask

   task automatic step(string tag);
      @(posedge CLKb);
      m_edge();
      #1 chk_all(tag);
   endtask

   task automatic async_reset(string tag);
      RST = 1;
      m_reset();
      #1 chk_all(tag);
      chk({tag, ".pc0"}, int'(PC), 0);
      chk({tag, ".len0"}, int'(LEN), 0);
      #1 RST = 0;
   endtask

   task automatic load3();
      logic [9:0] w [3];
      w[0] = 10'h0A1; w[1] = 10'h155; w[2] = 10'h3FF;
      for (int i = 0; i < 3; i++) begin
         SW = w[i];
         WR = 1;
         step("load3");
      end
      WR = 0;
   endtask

   initial begin
      #2 async_reset("reset");
      chk("reset.echo", int'(D_OUT), int'(SW));
      load3();
      chk("load.len", int'(LEN), 3);
      chk("load.full", int'(FULL), 0);
      SW = 10'h2C3;
      #1 chk("load.echo", int'(D_OUT), 'h2C3);
      MODE = 1;
      step("run");
      chk("run.d0", int'(D_OUT), 'h0A1);
      IR_TAKE = 1;
      step("ir1");
      IR_TAKE = 0;
      chk("ir1.d", int'(D_OUT), 'h155);
      chk("ir1.pc", int'(PC), 1);
      for (int i = 0; i < 5; i++) step("stall");
      chk("stall.d", int'(D_OUT), 'h155);
      EXT_TAKE = 1;
      step("ext");
      EXT_TAKE = 0;
      chk("ext.d", int'(D_OUT), 'h3FF);
      chk("ext.pc", int'(PC), 2);
      IR_TAKE = 1;
      step("halt");
      step("halt.take_ignored");
      IR_TAKE = 0;
      chk("halt.h", int'(HALTED), 1);
      chk("halt.d", int'(D_OUT), 0);
      chk("halt.pc", int'(PC), 2);
      WR = 1;
      step("halt.wr_ignored");
      WR = 0;
      MODE = 0;
      step("reload");
      for (int i = 0; i < 18; i++) begin
         SW = 10'(i);
         WR = 1;
         step("fill");
      end
      WR = 0;
      chk("fill.len", int'(LEN), 16);
      chk("fill.full", int'(FULL), 1);
      MODE = 1;
      step("fill.run");
      IR_TAKE = 1;
      for (int i = 0; i < 15; i++) step("fill.walk");
      chk("fill.mem15", int'(D_OUT), 15);
      step("fill.end");
      IR_TAKE = 0;
      chk("fill.halt", int'(HALTED), 1);
      MODE = 0;
      step("err.reload");
      load3();
      MODE = 1;
      step("err.run");
      IR_TAKE = 1;
      EXT_TAKE = 1;
      step("err.both");
      IR_TAKE = 0;
      EXT_TAKE = 0;
      chk("err.pc", int'(PC), 1);
      chk("err.flag", int'(TAKE_ERR), 1);
      MODE = 0;
      IR_TAKE = 1;
      step("err.mode0");
      IR_TAKE = 0;
      chk("err.cleared", int'(TAKE_ERR), 0);
      chk("err.len0", int'(LEN), 0);
      load3();
      MODE = 1;
      step("mid.run");
      IR_TAKE = 1;
      step("mid.take");
      IR_TAKE = 0;
      chk("mid.pc1", int'(PC), 1);
      #2 async_reset("mid.rst");
      MODE = 1;
      step("empty.run");
      chk("empty.halt", int'(HALTED), 1);
      MODE = 0;
      step("empty.back");
      for (int n = 0; n < 600; n++) begin
         @(negedge CLKb);
         if ($urandom_range(0, 19) == 0) MODE = ~MODE;
         SW = 10'($urandom);
         WR = $urandom_range(0, 1) == 1;
         IR_TAKE = $urandom_range(0, 3) == 0;
         EXT_TAKE = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 99) == 0) async_reset("rnd.rst");
         step("rnd");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL timeout: got running expected finish");
   end
endmodule
